// File: rtl/nios2_video_nco_clkgen_if.sv
// Configuration and status bundle for the video NCO clock generator.
//   cfg_wr   single-cycle write strobe for one channel increment
//   cfg_ch   channel index for cfg_wr
//   cfg_inc  new phase increment
//   ce_out   per-channel one-cycle clock-enable pulses
//   clk_out  per-channel ~50% duty divided clocks
//   locked   all channels stable for the settle period
// master: the configuring agent. slave: the clock generator.
interface nios2_video_nco_clkgen_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned CH_W   = 2
);
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic [NUM_CH-1:0] ce_out;
  logic [NUM_CH-1:0] clk_out;
  logic              locked;

  modport master (
    output cfg_wr, cfg_ch, cfg_inc,
    input  ce_out, clk_out, locked
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_inc,
    output ce_out, clk_out, locked
  );
endinterface

// File: rtl/nios2_video_nco_clkgen.sv
// Multi-channel numerically-controlled clock generator for the video subsystem.
// Each channel adds its phase increment to an accumulator every refclk edge;
// the carry out becomes a one-cycle clock enable and the accumulator MSB a
// ~50% duty divided clock. Increments are reprogrammable at runtime, and a
// settle counter drives `locked` once all channels have run undisturbed for
// LOCK_CYCLES edges.
// Ports:
//   refclk  sole clock, rising edge
//   rst     asynchronous active-high reset
//   bus     slave side of nios2_video_nco_clkgen_if (cfg_wr/cfg_ch/cfg_inc in,
//           ce_out/clk_out/locked out)
module nios2_video_nco_clkgen #(
  parameter int unsigned                    NUM_CH      = 3,
  parameter int unsigned                    ACC_W       = 32,
  parameter int unsigned                    CH_W        = 2,
  parameter logic [NUM_CH*ACC_W-1:0]        INIT_INC    = {32'hA8F5C28F, 32'h80000000, 32'h80000000},
  parameter int unsigned                    LOCK_CYCLES = 1024
) (
  input  logic                    refclk,
  input  logic                    rst,
  nios2_video_nco_clkgen_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic {
    SETTLE,
    LOCKED
  } lock_state_e;

  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic [31:0]       cfg_idx;
  logic              cfg_hit;

  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  inc_q [NUM_CH];
  logic [ACC_W:0]    sum   [NUM_CH];
  logic [NUM_CH-1:0] ce_q;
  logic [NUM_CH-1:0] clk_q;

  lock_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              locked_q, locked_d;

  assign cfg_ch  = bus.cfg_ch;
  assign cfg_inc = bus.cfg_inc;
  assign cfg_idx = 32'(cfg_ch);
  // Writes to nonexistent channels are dropped entirely, lock included.
  assign cfg_hit = bus.cfg_wr && (cfg_idx < NUM_CH);

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
    end
  end

  // An idle channel (inc == 0) needs no special case: sum equals acc, so the
  // accumulator and MSB hold and the carry stays low.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= INIT_INC[i*ACC_W +: ACC_W];
      end
      ce_q  <= '0;
      clk_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (cfg_hit && (cfg_idx == i)) begin
          inc_q[i] <= cfg_inc;
          acc_q[i] <= '0;
          ce_q[i]  <= 1'b0;
          clk_q[i] <= 1'b0;
        end else begin
          acc_q[i] <= sum[i][ACC_W-1:0];
          ce_q[i]  <= sum[i][ACC_W];
          clk_q[i] <= sum[i][ACC_W-1];
        end
      end
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q  <= SETTLE;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  // The counter reaches LOCK_CYCLES-1 on the LOCK_CYCLES-th edge after a
  // restart, so locked rises exactly LOCK_CYCLES edges later.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    locked_d = locked_q;
    if (cfg_hit) begin
      state_d  = SETTLE;
      cnt_d    = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LOCKED: begin
          locked_d = 1'b1;
        end
        default: begin
          state_d  = SETTLE;
          cnt_d    = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.ce_out  = ce_q;
  assign bus.clk_out = clk_q;
  assign bus.locked  = locked_q;

endmodule
